// File: rtl/muon_buffer_reader.sv
// Drains full muon buffers from the dual muon memories into an AXI-Stream master,
// then hands each buffer back to the writer through the MUON_BUF_CONTROL strobe sequence.
module muon_buffer_reader #(
    parameter int NUM_WIDTH  = 2,
    parameter int BUF_SHIFT  = 11,
    parameter int RD_LATENCY = 2,
    parameter int SETTLE     = 4,
    parameter int HOLD       = 4
) (
    input  logic                          AXI_CLK,
    input  logic                          RESET,
    input  logic                          ENABLE,
    input  logic [NUM_WIDTH:0]            BUF_NUM_FULL,
    input  logic [NUM_WIDTH-1:0]          BUF_RNUM,
    input  logic [31:0]                   BUF_WORD_COUNT,
    input  logic [31:0]                   TIME_TAG_A,
    input  logic [31:0]                   TIME_TAG_B,
    output logic                          MEM_EN,
    output logic [BUF_SHIFT+NUM_WIDTH-1:0] MEM_ADDR,
    input  logic [31:0]                   MEM_DATA0,
    input  logic [31:0]                   MEM_DATA1,
    output logic [31:0]                   M_TDATA,
    output logic                          M_TVALID,
    input  logic                          M_TREADY,
    output logic                          M_TLAST,
    output logic [31:0]                   MUON_BUF_CONTROL,
    output logic                          MUON_CONTROL_WRITTEN,
    output logic                          BUSY,
    output logic [15:0]                   BUF_DONE_CTR
);

    localparam int WCW  = BUF_SHIFT - 1;        // wide enough to hold the full word count
    localparam int CNTW = 9;
    localparam logic [WCW-1:0]  MAXW_W      = WCW'(2 ** (BUF_SHIFT - 2));
    localparam logic [31:0]     MAXW_32     = 32'(2 ** (BUF_SHIFT - 2));
    localparam logic [WCW-1:0]  ONE_W       = WCW'(1);
    localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE - 1);
    localparam logic [CNTW-1:0] HOLD_C      = CNTW'(HOLD);
    localparam logic [CNTW-1:0] REL_LAST    = CNTW'(2 * HOLD);
    localparam logic [CNTW-1:0] ACK_LAST    = CNTW'(255);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_HEADER, S_READ, S_RELEASE, S_ACK
    } state_t;

    state_t state_reg, state_next;

    logic [NUM_WIDTH-1:0] cur_buf_reg;
    logic [WCW-1:0]       wc_reg, wc_last_reg, ridx_reg, words_out_reg;
    logic [31:0]          ta_reg, tb_reg, control_reg;
    logic [CNTW-1:0]      cnt_reg;
    logic [1:0]           hdr_idx_reg, wr_ptr_reg, rd_ptr_reg;
    logic                 phase_reg;
    logic [RD_LATENCY-1:0] vld_reg;
    logic [2:0]           inflight_reg, fifo_cnt_reg;
    logic [15:0]          done_ctr_reg;
    logic [63:0]          fifo_mem [0:3];

    logic [WCW-1:0] wc_clamped;
    logic [63:0]    fifo_head;
    logic           beat_fire, push, pop, fifo_nonempty;

    assign wc_clamped    = (BUF_WORD_COUNT > MAXW_32) ? MAXW_W : BUF_WORD_COUNT[WCW-1:0];
    assign fifo_head     = fifo_mem[rd_ptr_reg];
    assign fifo_nonempty = (fifo_cnt_reg != 3'd0);
    assign beat_fire     = M_TVALID && M_TREADY;
    assign push          = vld_reg[RD_LATENCY-1];
    assign pop           = (state_reg == S_READ) && beat_fire && phase_reg;

    assign MUON_BUF_CONTROL = control_reg;
    assign BUF_DONE_CTR     = done_ctr_reg;
    assign BUSY             = (state_reg != S_IDLE);
    assign MEM_ADDR         = MEM_EN ? {cur_buf_reg, ridx_reg[BUF_SHIFT-3:0], 2'b00} : '0;

    always_ff @(posedge AXI_CLK) begin
        if (RESET) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next           = state_reg;
        M_TVALID             = 1'b0;
        M_TDATA              = 32'd0;
        M_TLAST              = 1'b0;
        MEM_EN               = 1'b0;
        MUON_CONTROL_WRITTEN = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (ENABLE && (BUF_NUM_FULL != '0)) state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_reg == SETTLE_LAST) state_next = S_HEADER;
            end
            S_HEADER: begin
                M_TVALID = 1'b1;
                case (hdr_idx_reg)
                    2'd0:    M_TDATA = {16'hA5A5, 16'(cur_buf_reg)};
                    2'd1:    M_TDATA = ta_reg;
                    default: M_TDATA = tb_reg;
                endcase
                // An empty buffer terminates the packet on the last header beat
                M_TLAST = (hdr_idx_reg == 2'd2) && (wc_reg == '0);
                if (beat_fire && (hdr_idx_reg == 2'd2))
                    state_next = (wc_reg == '0) ? S_RELEASE : S_READ;
            end
            S_READ: begin
                MEM_EN   = (ridx_reg < wc_reg) && (inflight_reg < 3'd4);
                M_TVALID = fifo_nonempty;
                M_TDATA  = phase_reg ? fifo_head[31:0] : fifo_head[63:32];
                M_TLAST  = fifo_nonempty && phase_reg && (words_out_reg == wc_last_reg);
                if (beat_fire && M_TLAST) state_next = S_RELEASE;
            end
            S_RELEASE: begin
                MUON_CONTROL_WRITTEN = (cnt_reg >= CNTW'(1)) && (cnt_reg <= HOLD_C);
                if (cnt_reg == REL_LAST) state_next = S_ACK;
            end
            S_ACK: begin
                if ((BUF_RNUM != cur_buf_reg) || (cnt_reg == ACK_LAST)) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Read-return pipeline: a set bit emerges when the memory data is valid
    always_ff @(posedge AXI_CLK) begin
        if (RESET) begin
            vld_reg <= '0;
        end else begin
            vld_reg[0] <= MEM_EN;
            for (int i = 1; i < RD_LATENCY; i++) vld_reg[i] <= vld_reg[i-1];
        end
    end

    always_ff @(posedge AXI_CLK) begin
        if (push) fifo_mem[wr_ptr_reg] <= {MEM_DATA0, MEM_DATA1};
    end

    always_ff @(posedge AXI_CLK) begin
        if (RESET) begin
            cur_buf_reg   <= '0;
            wc_reg        <= '0;
            wc_last_reg   <= '0;
            ta_reg        <= '0;
            tb_reg        <= '0;
            cnt_reg       <= '0;
            hdr_idx_reg   <= '0;
            ridx_reg      <= '0;
            words_out_reg <= '0;
            phase_reg     <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            fifo_cnt_reg  <= '0;
            inflight_reg  <= '0;
            control_reg   <= '0;
            done_ctr_reg  <= '0;
        end else begin
            if ((state_reg == S_IDLE) || (state_next != state_reg)) cnt_reg <= '0;
            else                                                     cnt_reg <= cnt_reg + CNTW'(1);

            if (state_reg == S_IDLE && state_next == S_SETTLE) cur_buf_reg <= BUF_RNUM;

            if (state_reg == S_SETTLE && state_next == S_HEADER) begin
                wc_reg        <= wc_clamped;
                wc_last_reg   <= wc_clamped - ONE_W;
                ta_reg        <= TIME_TAG_A;
                tb_reg        <= TIME_TAG_B;
                hdr_idx_reg   <= '0;
                ridx_reg      <= '0;
                words_out_reg <= '0;
                phase_reg     <= 1'b0;
            end

            if (state_reg == S_HEADER && beat_fire) hdr_idx_reg <= hdr_idx_reg + 2'd1;

            if (MEM_EN) ridx_reg <= ridx_reg + ONE_W;
            if (push)   wr_ptr_reg <= wr_ptr_reg + 2'd1;

            if (state_reg == S_READ && beat_fire) phase_reg <= ~phase_reg;
            if (pop) begin
                rd_ptr_reg    <= rd_ptr_reg + 2'd1;
                words_out_reg <= words_out_reg + ONE_W;
            end

            fifo_cnt_reg <= fifo_cnt_reg + 3'(push) - 3'(pop);
            // Credits cover both reads in flight and words parked in the FIFO
            inflight_reg <= inflight_reg + 3'(MEM_EN) - 3'(pop);

            if (state_reg != S_RELEASE && state_next == S_RELEASE)
                control_reg <= 32'(cur_buf_reg);

            if (state_reg == S_ACK && BUF_RNUM != cur_buf_reg)
                done_ctr_reg <= done_ctr_reg + 16'd1;
        end
    end

endmodule

// File: tb/tb_muon_buffer_reader.sv
// Directed bench for muon_buffer_reader: a queue model of the expected packet is checked
// against the stream, memory addresses, credit limit and release strobe every cycle.
module tb_muon_buffer_reader;

    localparam int NUM_WIDTH  = 2;
    localparam int BUF_SHIFT  = 11;
    localparam int RD_LATENCY = 2;
    localparam int SETTLE     = 4;
    localparam int HOLD       = 4;
    localparam int AW         = BUF_SHIFT + NUM_WIDTH;
    localparam int BUF_BYTES  = 2 ** BUF_SHIFT;
    localparam int MAX_WORDS  = 2 ** (BUF_SHIFT - 2);

    logic                 AXI_CLK = 1'b0;
    logic                 RESET = 1'b1;
    logic                 ENABLE = 1'b0;
    logic [NUM_WIDTH:0]   BUF_NUM_FULL = '0;
    logic [NUM_WIDTH-1:0] BUF_RNUM = '0;
    logic [31:0]          BUF_WORD_COUNT = '0;
    logic [31:0]          TIME_TAG_A = '0;
    logic [31:0]          TIME_TAG_B = '0;
    logic                 MEM_EN;
    logic [AW-1:0]        MEM_ADDR;
    logic [31:0]          MEM_DATA0 = '0;
    logic [31:0]          MEM_DATA1 = '0;
    logic [31:0]          M_TDATA;
    logic                 M_TVALID;
    logic                 M_TREADY = 1'b1;
    logic                 M_TLAST;
    logic [31:0]          MUON_BUF_CONTROL;
    logic                 MUON_CONTROL_WRITTEN;
    logic                 BUSY;
    logic [15:0]          BUF_DONE_CTR;

    muon_buffer_reader #(
        .NUM_WIDTH(NUM_WIDTH), .BUF_SHIFT(BUF_SHIFT), .RD_LATENCY(RD_LATENCY),
        .SETTLE(SETTLE), .HOLD(HOLD)
    ) dut (
        .AXI_CLK(AXI_CLK), .RESET(RESET), .ENABLE(ENABLE), .BUF_NUM_FULL(BUF_NUM_FULL),
        .BUF_RNUM(BUF_RNUM), .BUF_WORD_COUNT(BUF_WORD_COUNT), .TIME_TAG_A(TIME_TAG_A),
        .TIME_TAG_B(TIME_TAG_B), .MEM_EN(MEM_EN), .MEM_ADDR(MEM_ADDR),
        .MEM_DATA0(MEM_DATA0), .MEM_DATA1(MEM_DATA1), .M_TDATA(M_TDATA),
        .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TLAST(M_TLAST),
        .MUON_BUF_CONTROL(MUON_BUF_CONTROL), .MUON_CONTROL_WRITTEN(MUON_CONTROL_WRITTEN),
        .BUSY(BUSY), .BUF_DONE_CTR(BUF_DONE_CTR)
    );

    initial forever #5 AXI_CLK = ~AXI_CLK;

    // Memory contents are a fixed function of the byte address
    function automatic logic [31:0] mem_word(input int sel, input logic [AW-1:0] a);
        return (sel == 0) ? {16'hD0D0, 3'b000, a} : {16'h1D1D, 3'b000, a};
    endfunction

    // Two-cycle read memory: address registered, then data registered
    logic [AW-1:0] addr_pipe = '0;
    always @(posedge AXI_CLK) begin
        addr_pipe <= MEM_ADDR;
        MEM_DATA0 <= mem_word(0, addr_pipe);
        MEM_DATA1 <= mem_word(1, addr_pipe);
    end

    typedef struct packed { logic [31:0] data; logic last; } beat_t;
    beat_t         exp_q[$];
    logic [AW-1:0] exp_addr_q[$];

    int checks = 0, errors = 0;
    int cyc = 0, beat_cnt = 0, issued = 0, popped = 0;
    int wc_eff = 0, exp_buf = 0, exp_done = 0;
    int first_data_cyc = 0, last_cyc = 0, fall_cyc = 0, hi_run = 0;
    bit fall_seen = 0, prev_stall = 0, prev_written = 0, prev_last = 0, tready_mode = 0;
    logic [31:0] prev_data = '0, prev_control = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
        end
    endtask

    task automatic build_model(input int rnum, input int wc, input logic [31:0] ta, input logic [31:0] tb);
        logic [AW-1:0] a;
        exp_q.delete();
        exp_addr_q.delete();
        wc_eff  = (wc > MAX_WORDS) ? MAX_WORDS : wc;
        exp_buf = rnum;
        exp_q.push_back(beat_t'{data: 32'hA5A50000 + 32'(rnum), last: 1'b0});
        exp_q.push_back(beat_t'{data: ta, last: 1'b0});
        exp_q.push_back(beat_t'{data: tb, last: (wc_eff == 0)});
        for (int w = 0; w < wc_eff; w++) begin
            a = AW'(rnum * BUF_BYTES + w * 4);
            exp_addr_q.push_back(a);
            exp_q.push_back(beat_t'{data: mem_word(0, a), last: 1'b0});
            exp_q.push_back(beat_t'{data: mem_word(1, a), last: (w == wc_eff - 1)});
        end
        beat_cnt = 0; issued = 0; popped = 0; fall_seen = 0; hi_run = 0;
        prev_stall = 0; prev_written = 0; first_data_cyc = 0; last_cyc = 0;
        BUF_RNUM = NUM_WIDTH'(rnum);
        BUF_WORD_COUNT = 32'(wc);
        TIME_TAG_A = ta;
        TIME_TAG_B = tb;
    endtask

    // Per-cycle comparison of all meaningful DUT outputs against the model
    task automatic check_cycle();
        beat_t e;
        cyc++;
        if (RESET) begin
            prev_stall = 0;
            prev_written = 0;
            return;
        end
        if (prev_stall) begin
            chk("stall_valid", 32'(M_TVALID), 32'd1);
            chk("stall_data", M_TDATA, prev_data);
            chk("stall_last", 32'(M_TLAST), 32'(prev_last));
        end
        if (MEM_EN) begin
            chk("credit_below_4", 32'((issued - popped) < 4), 32'd1);
            if (exp_addr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_mem_en: got addr 0x%04h expected no read", MEM_ADDR);
            end else begin
                chk("mem_addr", 32'(MEM_ADDR), 32'(exp_addr_q.pop_front()));
            end
            issued++;
        end
        if (M_TVALID && M_TREADY) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_beat: got 0x%08h expected no beat", M_TDATA);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", M_TDATA, e.data);
                chk("beat_last", 32'(M_TLAST), 32'(e.last));
            end
            beat_cnt++;
            if (beat_cnt == 4) first_data_cyc = cyc;
            if (M_TLAST) last_cyc = cyc;
            if (beat_cnt >= 5 && (beat_cnt % 2) == 1) popped++;
        end
        prev_stall = M_TVALID && !M_TREADY;
        prev_data  = M_TDATA;
        prev_last  = M_TLAST;
        if (MUON_CONTROL_WRITTEN && !prev_written) begin
            chk("control_before_strobe", prev_control, 32'(exp_buf));
            hi_run = 1;
        end else if (MUON_CONTROL_WRITTEN) begin
            hi_run++;
        end else if (prev_written) begin
            chk("strobe_high_len", 32'(hi_run), 32'(HOLD));
            fall_seen = 1;
            fall_cyc  = cyc;
        end
        prev_written = MUON_CONTROL_WRITTEN;
        prev_control = MUON_BUF_CONTROL;
    endtask

    task automatic tick();
        @(negedge AXI_CLK);
        M_TREADY = tready_mode ? ~M_TREADY : 1'b1;
        check_cycle();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tvalid"}, 32'(M_TVALID), 32'd0);
        chk({tag, "_tdata"}, M_TDATA, 32'd0);
        chk({tag, "_tlast"}, 32'(M_TLAST), 32'd0);
        chk({tag, "_mem_en"}, 32'(MEM_EN), 32'd0);
        chk({tag, "_mem_addr"}, 32'(MEM_ADDR), 32'd0);
        chk({tag, "_control"}, MUON_BUF_CONTROL, 32'd0);
        chk({tag, "_written"}, 32'(MUON_CONTROL_WRITTEN), 32'd0);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
        chk({tag, "_done_ctr"}, 32'(BUF_DONE_CTR), 32'd0);
    endtask

    // Streams one buffer described by the model; ENABLE drops as soon as the DUT is busy
    task automatic run_buffer(input int rnum, input bit do_ack);
        int n;
        BUF_NUM_FULL = 1;
        ENABLE = 1'b1;
        n = 0;
        while (!BUSY && n < 50) begin tick(); n++; end
        chk("went_busy", 32'(BUSY), 32'd1);
        ENABLE = 1'b0;
        n = 0;
        while (!fall_seen && n < 5000) begin tick(); n++; end
        chk("release_seen", 32'(fall_seen), 32'd1);
        chk("beats_left", 32'(exp_q.size()), 32'd0);
        chk("addrs_left", 32'(exp_addr_q.size()), 32'd0);
        if (!tready_mode && wc_eff > 0)
            chk("throughput", 32'(last_cyc - first_data_cyc), 32'(2 * wc_eff - 1));
        if (do_ack) begin
            BUF_RNUM = NUM_WIDTH'(rnum + 1);
            BUF_NUM_FULL = 0;
            n = 0;
            while (BUSY && n < 600) begin tick(); n++; end
            chk("idle_after_ack", 32'(BUSY), 32'd0);
            exp_done++;
            chk("done_ctr", 32'(BUF_DONE_CTR), 32'(exp_done));
        end else begin
            n = 0;
            while (BUSY && n < 600) begin tick(); n++; end
            chk("ack_timeout_len", 32'(cyc - fall_cyc), 32'(HOLD + 256));
            chk("done_ctr_on_timeout", 32'(BUF_DONE_CTR), 32'(exp_done));
        end
        $display("buffer %0d wc=%0d ack=%0d: beats=%0d reads=%0d checks=%0d errors=%0d",
                 rnum, wc_eff, do_ack, beat_cnt, issued, checks, errors);
    endtask

    initial begin
        int n;
        repeat (3) tick();
        check_zero("reset");
        RESET = 1'b0;
        tick();

        // Basic buffer, TREADY held high
        build_model(2, 3, 32'h100, 32'h200);
        chk("pin_header", exp_q[0].data, 32'hA5A50002);
        chk("pin_beats", 32'(exp_q.size()), 32'd9);
        chk("pin_addr0", 32'(exp_addr_q[0]), 32'h1000);
        chk("pin_addr2", 32'(exp_addr_q[2]), 32'h1008);
        chk("pin_last_flag", 32'(exp_q[8].last), 32'd1);
        run_buffer(2, 1);

        // Same shape with TREADY toggling every cycle
        tready_mode = 1;
        build_model(3, 3, 32'h100, 32'h200);
        run_buffer(3, 1);
        tready_mode = 0;

        // Empty buffer: header only, TLAST on TB
        build_model(0, 0, 32'hCAFE0001, 32'hCAFE0002);
        chk("pin_empty_beats", 32'(exp_q.size()), 32'd3);
        run_buffer(0, 1);

        // Oversized count is clamped to a full buffer
        build_model(1, 32'hFFFF, 32'h11111111, 32'h22222222);
        chk("pin_clamp_beats", 32'(exp_q.size()), 32'd1027);
        chk("pin_clamp_last_addr", 32'(exp_addr_q[MAX_WORDS-1]), 32'h0FFC);
        run_buffer(1, 1);

        // No acknowledge: timeout, then the same buffer is streamed again
        build_model(2, 1, 32'h33, 32'h44);
        run_buffer(2, 0);
        build_model(2, 1, 32'h33, 32'h44);
        run_buffer(2, 1);

        // Reset in the middle of the data phase
        build_model(1, 4, 32'h55, 32'h66);
        BUF_NUM_FULL = 1;
        ENABLE = 1'b1;
        n = 0;
        while (beat_cnt < 8 && n < 200) begin tick(); n++; end
        chk("reached_5_data_beats", 32'(beat_cnt >= 8), 32'd1);
        RESET = 1'b1;
        tick();
        check_zero("midreset");
        exp_done = 0;
        RESET = 1'b0;
        build_model(1, 4, 32'h55, 32'h66);
        run_buffer(1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muon_buffer_reader.md
Name: muon_buffer_reader

Overview:
- Readout engine for the muon buffers on the AXI side. Drains each full muon buffer from the read port of the dual-ported muon memories (DATA0/DATA1 pair) into an AXI-Stream master.
- After a buffer is streamed, releases it back to the muon buffer writer by issuing the MUON_BUF_CONTROL write sequence (value, then CONTROL_WRITTEN high then low).
- Sits between the muon memories/status registers and the DMA stream.

Parameters:
- NUM_WIDTH, 2, buffer number width (NBUF = 2**NUM_WIDTH).
- BUF_SHIFT, 11, byte-address bits per buffer; max words per buffer = 2**(BUF_SHIFT-2).
- RD_LATENCY, 2, memory read latency in cycles, EN to data valid.
- SETTLE, 4, cycles to wait after selecting a buffer before sampling word count and time tags (covers the status synchronizers).
- HOLD, 4, cycles CONTROL_WRITTEN is held high, and then held low, in the release sequence.

Ports:
- AXI_CLK  in  1  sole clock.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  readout enable; sampled only in IDLE.
- BUF_NUM_FULL  in  NUM_WIDTH+1  number of full buffers (status field).
- BUF_RNUM  in  NUM_WIDTH  next buffer to read (status field).
- BUF_WORD_COUNT  in  32  word count of buffer BUF_RNUM.
- TIME_TAG_A  in  32  buffer start time tag.
- TIME_TAG_B  in  32  buffer end time tag.
- MEM_EN  out  1  memory read enable.
- MEM_ADDR  out  BUF_SHIFT+NUM_WIDTH  byte address; {buf, word<<2}.
- MEM_DATA0  in  32  read data, memory 0.
- MEM_DATA1  in  32  read data, memory 1.
- M_TDATA  out  32  stream data.
- M_TVALID  out  1  stream valid.
- M_TREADY  in  1  stream ready.
- M_TLAST  out  1  last beat of buffer.
- MUON_BUF_CONTROL  out  32  buffer number to release (zero-extended).
- MUON_CONTROL_WRITTEN  out  1  release strobe.
- BUSY  out  1  high whenever state is not IDLE.
- BUF_DONE_CTR  out  16  buffers released since reset; wraps at 2**16.

Behaviour:
- Reset values: every output 0; state IDLE; FIFO empty; all counters 0.
- IDLE -> SETTLE when ENABLE=1 and BUF_NUM_FULL!=0. On entry, latch CUR_BUF=BUF_RNUM.
- SETTLE: wait SETTLE cycles, then latch:
  - WC = min(BUF_WORD_COUNT, 2**(BUF_SHIFT-2)), zero-extended; counts above the maximum are clamped.
  - TA = TIME_TAG_A and TB = TIME_TAG_B.
  - Then go to HEADER.
- HEADER: emit 3 beats in order: {16'hA5A5, NUM_WIDTH-bit CUR_BUF zero-extended to 16}, TA, TB. Then go to READ.
- A beat transfers only when M_TVALID && M_TREADY. M_TDATA/M_TLAST stay stable while M_TVALID=1 and M_TREADY=0.
- READ:
  - Issue MEM_EN=1 with MEM_ADDR={CUR_BUF, RIDX, 2'b00} when RIDX<WC and (outstanding reads + FIFO occupancy) < 4. Increment RIDX per issue.
  - Data returns RD_LATENCY cycles after EN and is pushed as one {DATA0, DATA1} pair into a 4-entry FIFO. The FIFO never overflows because of the credit rule.
  - Each pair is emitted as two beats: DATA0, then DATA1.
  - M_TLAST=1 on the DATA1 beat of word WC-1.
  - After that beat is accepted, go to RELEASE.
  - WC=0: skip READ. M_TLAST is asserted on the TB header beat instead.
- RELEASE:
  - Drive MUON_BUF_CONTROL=CUR_BUF.
  - One cycle later, MUON_CONTROL_WRITTEN=1 for HOLD cycles, then 0 for HOLD cycles.
  - The writer acts on the falling edge.
  - Then go to ACK.
- ACK:
  - Wait until BUF_RNUM != CUR_BUF, then increment BUF_DONE_CTR and return to IDLE.
  - Timeout after 256 cycles: return to IDLE without incrementing. The next IDLE pass re-reads the same buffer.
- ENABLE deasserted mid-buffer has no effect; the current buffer completes through ACK.
- RESET mid-operation:
  - Abort immediately; M_TVALID=0; MUON_CONTROL_WRITTEN=0; discard FIFO and in-flight reads.
  - No partial release is issued; the buffer is re-read after reset.
- CUR_BUF wraps naturally modulo NBUF. MEM_ADDR word field uses RIDX[BUF_SHIFT-3:0].
- Throughput: with M_TREADY=1, one beat per cycle sustained after the initial RD_LATENCY fill.

Test Plan:
- NUM_FULL=1, RNUM=2, WC=3, TA=0x100, TB=0x200, TREADY=1:
  - stream A5A50002, 00000100, 00000200, D0[0], D1[0], D0[1], D1[1], D0[2], D1[2], with TLAST on the 9th beat only;
  - MEM_ADDR = 0x1000, 0x1004, 0x1008;
  - CONTROL=2; WRITTEN high 4 cycles, then low 4 cycles;
  - RNUM->3 gives BUF_DONE_CTR=1.
- Same as above with TREADY toggling 1/0 each cycle and RD_LATENCY=2:
  - identical beat sequence, no lost or duplicated words;
  - never more than 4 reads outstanding+buffered.
- WC=0 -> exactly 3 header beats, TLAST on beat 3, no MEM_EN, release issued.
- WC=0xFFFF with BUF_SHIFT=11 -> clamped to 512 words; last address {buf, 0x7FC}; 1027 beats total.
- No RNUM change after release -> ACK times out after 256 cycles, counter unchanged, same buffer re-streamed on the next pass.
- RESET asserted after 5 data beats -> all outputs 0 next cycle. After release of reset with NUM_FULL=1, the full buffer is streamed from the header again.
